// File: rtl/mem_writer.sv
// mem_writer: accepts one bounds-checked little-endian store and writes it one byte per clock.
// Optional build macro MEM_WRITER_COUNT_EN adds a saturating bytes_written counter output.
module mem_writer #(
    parameter int unsigned AW    = 6,
    parameter int unsigned DW    = 8,
    parameter int unsigned EXTRA = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [AW:0]              addr,
    input  logic [EXTRA-1:0]         extra,
    input  logic [(2**EXTRA)*DW-1:0] data,
    input  logic [AW:0]              lower_bound,
    input  logic [AW:0]              upper_bound,
    output logic                     wr_en,
    output logic [AW:0]              wr_addr,
    output logic [DW-1:0]            wr_data,
    output logic                     done,
    output logic                     error
`ifdef MEM_WRITER_COUNT_EN
    ,
    output logic [AW+1:0]            bytes_written
`endif
);

    localparam int unsigned DBW = (2**EXTRA) * DW;

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StReject,
        StDone
    } state_e;

    state_e               state_q, state_d;
    logic [EXTRA-1:0]     cnt_q, cnt_d;
    logic [AW:0]          base_q, base_d;
    logic [EXTRA-1:0]     extra_q, extra_d;
    logic [DBW-1:0]       data_q, data_d;
    logic                 wr_en_q, wr_en_d;
    logic [AW:0]          wr_addr_q, wr_addr_d;
    logic [DW-1:0]        wr_data_q, wr_data_d;
    logic                 done_q, done_d;
    logic                 error_q, error_d;

    logic                 accept;
    logic [AW+1:0]        end_addr;
    logic                 in_bounds;
    logic [EXTRA-1:0]     cnt_nxt;

    // End address is one bit wider than the bus so a run past the top is caught, not wrapped.
    assign end_addr  = (AW+2)'(addr) + (AW+2)'(extra);
    assign in_bounds = (addr >= lower_bound) &&
                       (end_addr <= (AW+2)'(upper_bound)) &&
                       !end_addr[AW+1];

    assign req_ready = (state_q == StIdle);
    assign accept    = req_valid && req_ready;
    assign cnt_nxt   = cnt_q + EXTRA'(1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        base_d    = base_q;
        extra_d   = extra_q;
        data_d    = data_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        done_d    = 1'b0;
        error_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    base_d  = addr;
                    extra_d = extra;
                    data_d  = data;
                    cnt_d   = '0;
                    if (in_bounds) begin
                        state_d   = StWrite;
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr;
                        wr_data_d = data[DW-1:0];
                    end else begin
                        state_d = StReject;
                    end
                end
            end
            StWrite: begin
                if (cnt_q == extra_q) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                end else begin
                    // Outputs are registered, so stage the byte for the next count now.
                    cnt_d     = cnt_nxt;
                    wr_en_d   = 1'b1;
                    wr_addr_d = base_q + (AW+1)'(cnt_nxt);
                    wr_data_d = data_q[cnt_nxt*DW +: DW];
                end
            end
            StReject: begin
                state_d = StDone;
                done_d  = 1'b1;
                error_d = 1'b1;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            base_q    <= '0;
            extra_q   <= '0;
            data_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            base_q    <= base_d;
            extra_q   <= extra_d;
            data_q    <= data_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign done    = done_q;
    assign error   = error_q;

`ifdef MEM_WRITER_COUNT_EN
    logic [AW+1:0] bytes_written_q, bytes_written_d;

    always_comb begin
        bytes_written_d = bytes_written_q;
        if (wr_en_q && !(&bytes_written_q)) begin
            bytes_written_d = bytes_written_q + (AW+2)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bytes_written_q <= '0;
        end else begin
            bytes_written_q <= bytes_written_d;
        end
    end

    assign bytes_written = bytes_written_q;
`endif

endmodule

// File: tb/tb_mem_writer.sv
// Scoreboard bench for mem_writer: stimulus pushes expected writes/done, a negedge monitor pops.
module tb_mem_writer;

    localparam int unsigned AW    = 6;
    localparam int unsigned DW    = 8;
    localparam int unsigned EXTRA = 4;
    localparam int unsigned DBW   = (2**EXTRA) * DW;

    logic               clk = 1'b0;
    logic               reset;
    logic               req_valid;
    logic               req_ready;
    logic [AW:0]        addr;
    logic [EXTRA-1:0]   extra;
    logic [DBW-1:0]     data;
    logic [AW:0]        lower_bound;
    logic [AW:0]        upper_bound;
    logic               wr_en;
    logic [AW:0]        wr_addr;
    logic [DW-1:0]      wr_data;
    logic               done;
    logic               error;
`ifdef MEM_WRITER_COUNT_EN
    logic [AW+1:0]      bytes_written;
`endif

    mem_writer #(.AW(AW), .DW(DW), .EXTRA(EXTRA)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .addr        (addr),
        .extra       (extra),
        .data        (data),
        .lower_bound (lower_bound),
        .upper_bound (upper_bound),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .done        (done),
        .error       (error)
`ifdef MEM_WRITER_COUNT_EN
        ,
        .bytes_written (bytes_written)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        bit            is_done;
        int            cyc;
        logic [AW:0]   addr;
        logic [DW-1:0] data;
        bit            err;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: outputs are sampled mid-cycle, cyc labels the cycle being observed.
    always @(negedge clk) begin
        exp_t e;
        if (wr_en === 1'b1 || done === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("unexpected_output", {30'd0, wr_en, done}, 32'd0);
            end else begin
                e = sbq.pop_front();
                if (e.is_done) begin
                    chk("done_pulse", {31'd0, done}, 32'd1);
                    chk("done_wr_en", {31'd0, wr_en}, 32'd0);
                    chk("done_error", {31'd0, error}, {31'd0, e.err});
                    chk("done_cycle", cyc, e.cyc);
                    chk("done_not_ready", {31'd0, req_ready}, 32'd0);
                end else begin
                    chk("wr_strobe", {31'd0, wr_en}, 32'd1);
                    chk("wr_addr", {25'd0, wr_addr}, {25'd0, e.addr});
                    chk("wr_data", {24'd0, wr_data}, {24'd0, e.data});
                    chk("wr_cycle", cyc, e.cyc);
                end
            end
        end else if (error === 1'b1) begin
            chk("stray_error", {31'd0, error}, 32'd0);
        end
    end

    // Called at a negedge. trunc: expect only byte 0 (reset will cut the request short).
    task automatic send(input logic [AW:0] a, input logic [EXTRA-1:0] x, input logic [DBW-1:0] d,
                        input logic [AW:0] lb, input logic [AW:0] ub, input bit err,
                        input bit hold, input bit trunc, output int t_acc);
        bit ok;
        exp_t e;
        ok = 1'b0;
        t_acc = -1;
        addr = a; extra = x; data = d; lower_bound = lb; upper_bound = ub;
        req_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            if (req_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            chk("accept_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        t_acc = cyc;
        if (err) begin
            e = '{is_done: 1'b1, cyc: t_acc + 2, addr: '0, data: '0, err: 1'b1};
            sbq.push_back(e);
        end else begin
            for (int i = 0; i <= int'(x); i++) begin
                e = '{is_done: 1'b0, cyc: t_acc + 1 + i, addr: a + (AW+1)'(i),
                      data: d[i*DW +: DW], err: 1'b0};
                sbq.push_back(e);
                if (trunc) break;
            end
            if (!trunc) begin
                e = '{is_done: 1'b1, cyc: t_acc + 2 + int'(x), addr: '0, data: '0, err: 1'b0};
                sbq.push_back(e);
            end
        end
        @(negedge clk);
        if (!hold) req_valid = 1'b0;
        // Captured copy must be used; scramble the live inputs.
        addr = ~a;
        data = ~d;
        extra = ~x;
        lower_bound = '0;
        upper_bound = '1;
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && sbq.size() != 0; k++) @(negedge clk);
        chk("drain_empty", sbq.size(), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    localparam logic [DBW-1:0] PAT = 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F;

    initial begin
        int t1, t2, tr;
        reset = 1'b1; req_valid = 1'b0; addr = '0; extra = '0; data = '0;
        lower_bound = '0; upper_bound = '1;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
        chk("rst_wr_addr", {25'd0, wr_addr}, 32'd0);
        chk("rst_wr_data", {24'd0, wr_data}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_error", {31'd0, error}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Basic 4-byte store, single byte, and bound edges (end==ub legal, end==ub+1 rejected).
        send(7'd10, 4'd3, 128'h44332211, 7'd0, 7'd127, 1'b0, 1'b0, 1'b0, t1); drain();
        send(7'd5, 4'd0, 128'hAB, 7'd0, 7'd127, 1'b0, 1'b0, 1'b0, t1); drain();
        send(7'd120, 4'd8, PAT, 7'd0, 7'd127, 1'b1, 1'b0, 1'b0, t1); drain();
        send(7'd119, 4'd8, PAT, 7'd0, 7'd127, 1'b0, 1'b0, 1'b0, t1); drain();
        send(7'd20, 4'd3, PAT, 7'd0, 7'd22, 1'b1, 1'b0, 1'b0, t1); drain();
        send(7'd20, 4'd3, PAT, 7'd0, 7'd23, 1'b0, 1'b0, 1'b0, t1); drain();
        send(7'd3, 4'd0, 128'h55, 7'd4, 7'd127, 1'b1, 1'b0, 1'b0, t1); drain();
        send(7'd4, 4'd0, 128'h66, 7'd4, 7'd127, 1'b0, 1'b0, 1'b0, t1); drain();
        send(7'd48, 4'd15, PAT, 7'd0, 7'd127, 1'b0, 1'b0, 1'b0, t1); drain();
        send(7'd127, 4'd15, PAT, 7'd0, 7'd127, 1'b1, 1'b0, 1'b0, t1); drain();

        // Back-to-back with req_valid held high.
        send(7'd64, 4'd1, 128'hBEEF, 7'd0, 7'd127, 1'b0, 1'b1, 1'b0, t1);
        addr = 7'd70; extra = 4'd1; data = 128'hCAFE; lower_bound = 7'd0; upper_bound = 7'd127;
        chk("b2b_ready_low_t1", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        chk("b2b_ready_low_t2", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        chk("b2b_ready_low_t3", {31'd0, req_ready}, 32'd0);
        send(7'd70, 4'd1, 128'hCAFE, 7'd0, 7'd127, 1'b0, 1'b0, 1'b0, t2);
        chk("b2b_second_accept", t2, t1 + 4);
        drain();

        // Reset taking effect after the first byte of an 8-byte store.
        send(7'd80, 4'd7, PAT, 7'd0, 7'd127, 1'b0, 1'b0, 1'b1, tr);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_wr_en_t2", {31'd0, wr_en}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_wr_en_t3", {31'd0, wr_en}, 32'd0);
        chk("rst_mid_ready", {31'd0, req_ready}, 32'd1);
`ifdef MEM_WRITER_COUNT_EN
        chk("rst_mid_count", {24'd0, bytes_written}, 32'd0);
`endif
        repeat (20) @(negedge clk);
        chk("rst_mid_queue", sbq.size(), 32'd0);

        // Reset together with a request: nothing may be accepted.
        addr = 7'd30; extra = 4'd2; data = PAT; lower_bound = '0; upper_bound = 7'd127;
        reset = 1'b1; req_valid = 1'b1;
        @(negedge clk);
        reset = 1'b0; req_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("rst_valid_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_valid_queue", sbq.size(), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got cycle %0d, expected completion", cyc);
        $fatal(1, "timeout");
    end

endmodule
